// File: rtl/mc_nbf_pkg.sv
// Shared types for the NBF credit loader: record struct macro, FSM states and
// the record-kind decode.
`ifndef MC_NBF_PKG_MACROS
`define MC_NBF_PKG_MACROS
`define DECLARE_BSG_NBF_S(cord_w, addr_w, data_w) \
  typedef struct packed { \
    logic [cord_w-1:0] x_cord; \
    logic [cord_w-1:0] y_cord; \
    logic [addr_w-1:0] epa; \
    logic [data_w-1:0] data; \
  } bsg_nbf_s
`endif

package mc_nbf_pkg;

  typedef enum logic [1:0] {eRun, eFence, eDrain, eDone} state_e;

  typedef enum logic [1:0] {eKindStore, eKindFence, eKindFinish, eKindDrop} nbf_kind_e;

  localparam logic [1:0] op_remote_store_lp = 2'b01;
  localparam logic [3:0] op_ex_store_lp     = 4'b1111;

  function automatic nbf_kind_e nbf_decode(input logic is_ctrl,
                                           input logic all_ones,
                                           input logic epa_zero);
    if (!is_ctrl)      return eKindStore;
    else if (all_ones) return eKindFinish;
    else if (epa_zero) return eKindFence;
    else               return eKindDrop;
  endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// Saturation-free up/down counter; simultaneous up and down leave it unchanged.
module bsg_counter_up_down #(
  parameter int max_val_p  = 16,
  parameter int init_val_p = 0,
  localparam int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)               count_o <= width_lp'(init_val_p);
    else if (up_i & ~down_i)   count_o <= count_o + width_lp'(1);
    else if (down_i & ~up_i)   count_o <= count_o - width_lp'(1);
  end

endmodule

// File: rtl/bsg_serial_in_parallel_out_full.sv
// Collects els_p flits into one wide word; the first flit lands in the LSBs.
module bsg_serial_in_parallel_out_full #(
  parameter int width_p = 8,
  parameter int els_p   = 4,
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic [els_p*width_p-1:0]   data_o,
  output logic                       v_o,
  input  logic                       yumi_i
);

  logic [cnt_width_lp-1:0]  count;
  logic [els_p*width_p-1:0] data_r;
  logic                     full, accept;
  logic [cnt_width_lp-1:0]  wr_idx;

  assign full    = (count == cnt_width_lp'(els_p));
  assign v_o     = full;
  // A word being consumed frees slot 0 in the same cycle, keeping full rate.
  assign ready_o = ~full | yumi_i;
  assign accept  = v_i & ready_o;
  assign wr_idx  = yumi_i ? '0 : count;
  assign data_o  = data_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count  <= '0;
      data_r <= '0;
    end else begin
      if (yumi_i)      count <= accept ? cnt_width_lp'(1) : '0;
      else if (accept) count <= count + cnt_width_lp'(1);
      for (int i = 0; i < els_p; i++) begin
        if (accept && (wr_idx == cnt_width_lp'(i)))
          data_r[i*width_p +: width_p] <= data_i;
      end
    end
  end

endmodule

// File: rtl/mc_nbf_credit_loader.sv
// Turns NBF records from the stream link into credit-limited remote stores.
// eRun: decode/issue | eFence: hold until credits==0 | eDrain: wait for credits==0 | eDone: idle until reset
module mc_nbf_credit_loader
  import mc_nbf_pkg::*;
#(
  parameter int addr_width_p        = 28,
  parameter int data_width_p        = 32,
  parameter int x_cord_width_p      = 7,
  parameter int y_cord_width_p      = 7,
  parameter int load_id_width_p     = 12,
  parameter int stream_data_width_p = 32,
  parameter int nbf_cord_width_p    = 8,
  parameter int nbf_addr_width_p    = 32,
  parameter int nbf_data_width_p    = 32,
  parameter int max_out_credits_p   = 16,
  localparam int credit_width_lp = $clog2(max_out_credits_p + 1),
  localparam int packet_width_lp = addr_width_p + 2 + 4 + data_width_p + load_id_width_p
                                   + 2*y_cord_width_p + 2*x_cord_width_p
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [x_cord_width_p-1:0]      my_x_i,
  input  logic [y_cord_width_p-1:0]      my_y_i,
  input  logic                           stream_v_i,
  input  logic [stream_data_width_p-1:0] stream_data_i,
  output logic                           stream_ready_o,
  output logic [packet_width_lp-1:0]     packet_o,
  output logic                           v_o,
  input  logic                           ready_i,
  input  logic                           credit_return_v_i,
  output logic [credit_width_lp-1:0]     credits_used_o,
  output logic                           done_o,
  output logic                           error_o
);

  localparam int nbf_width_lp = 2*nbf_cord_width_p + nbf_addr_width_p + nbf_data_width_p;
  localparam int flits_lp     = (nbf_width_lp + stream_data_width_p - 1) / stream_data_width_p;
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  `DECLARE_BSG_NBF_S(nbf_cord_width_p, nbf_addr_width_p, nbf_data_width_p);

  typedef struct packed {
    logic [addr_width_p-1:0]    addr;
    logic [1:0]                 op;
    logic [3:0]                 op_ex;
    logic [data_width_p-1:0]    payload;
    logic [load_id_width_p-1:0] load_id;
    logic [y_cord_width_p-1:0]  src_y_cord;
    logic [x_cord_width_p-1:0]  src_x_cord;
    logic [y_cord_width_p-1:0]  y_cord;
    logic [x_cord_width_p-1:0]  x_cord;
  } packet_s;

  logic [flits_lp*stream_data_width_p-1:0] sipo_data;
  logic        sipo_v, sipo_ready, sipo_yumi, in_done;
  bsg_nbf_s    rec;
  nbf_kind_e   kind;
  state_e      state, state_n;
  packet_s     pkt;
  logic        issue_v, issue, underflow, credit_down;
  logic [credit_width_lp-1:0] credits;
  logic        unused_bits;

  assign in_done = (state == eDone);

  bsg_serial_in_parallel_out_full #(
    .width_p(stream_data_width_p),
    .els_p  (flits_lp)
  ) sipo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (stream_v_i & ~in_done),
    .data_i (stream_data_i),
    .ready_o(sipo_ready),
    .data_o (sipo_data),
    .v_o    (sipo_v),
    .yumi_i (sipo_yumi)
  );

  assign stream_ready_o = sipo_ready & ~in_done & ~reset_i;

  assign rec  = sipo_data[nbf_width_lp-1:0];
  assign kind = nbf_decode((rec.x_cord == '1) && (rec.y_cord == '1),
                           &sipo_data[nbf_width_lp-1:0],
                           rec.epa == '0);
  assign unused_bits = ^{sipo_data, rec};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= eRun;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    issue_v   = 1'b0;
    sipo_yumi = 1'b0;
    case (state)
      eRun: begin
        if (sipo_v) begin
          case (kind)
            eKindStore: begin
              issue_v   = (credits < max_credits_lp);
              sipo_yumi = issue_v & ready_i;
            end
            eKindFence: begin
              sipo_yumi = 1'b1;
              state_n   = eFence;
            end
            eKindFinish: begin
              sipo_yumi = 1'b1;
              state_n   = eDrain;
            end
            default: sipo_yumi = 1'b1;
          endcase
        end
      end
      eFence:  if (credits == '0) state_n = eRun;
      eDrain:  if (credits == '0) state_n = eDone;
      default: state_n = state;
    endcase
  end

  assign issue       = issue_v & ready_i;
  assign underflow   = credit_return_v_i & ~issue & (credits == '0);
  assign credit_down = credit_return_v_i & ~underflow;

  bsg_counter_up_down #(
    .max_val_p (max_out_credits_p),
    .init_val_p(0)
  ) credit_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (issue),
    .down_i (credit_down),
    .count_o(credits)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)        error_o <= 1'b0;
    else if (underflow) error_o <= 1'b1;
  end

  always_comb begin
    pkt            = '0;
    pkt.addr       = rec.epa[addr_width_p-1:0];
    pkt.op         = op_remote_store_lp;
    pkt.op_ex      = op_ex_store_lp;
    pkt.payload    = rec.data[data_width_p-1:0];
    pkt.load_id    = '0;
    pkt.src_y_cord = my_y_i;
    pkt.src_x_cord = my_x_i;
    pkt.y_cord     = rec.y_cord[y_cord_width_p-1:0];
    pkt.x_cord     = rec.x_cord[x_cord_width_p-1:0];
  end

  assign v_o            = issue_v;
  assign packet_o       = issue_v ? pkt : '0;
  assign credits_used_o = credits;
  assign done_o         = in_done;

endmodule

// File: tb/tb_mc_nbf_credit_loader.sv
// Randomised scenario bench for mc_nbf_credit_loader with a queue-based model.
module tb_mc_nbf_credit_loader;

  localparam int AW = 28, DW = 32, XW = 7, YW = 7, LW = 12, SDW = 32;
  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    op;
    logic [3:0]    op_ex;
    logic [DW-1:0] payload;
    logic [LW-1:0] load_id;
    logic [YW-1:0] src_y;
    logic [XW-1:0] src_x;
    logic [YW-1:0] y;
    logic [XW-1:0] x;
  } pkt_t;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [31:0] epa;
    logic [31:0] data;
  } rec_t;

  localparam int PW = $bits(pkt_t);

  logic           clk, rst;
  logic [XW-1:0]  my_x;
  logic [YW-1:0]  my_y;
  logic           stream_v, stream_ready;
  logic [SDW-1:0] stream_data;
  logic [PW-1:0]  packet;
  logic           v, ready, ret, done, err;
  logic [CW-1:0]  credits;

  mc_nbf_credit_loader #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .load_id_width_p(LW), .stream_data_width_p(SDW), .nbf_cord_width_p(8),
    .nbf_addr_width_p(32), .nbf_data_width_p(32), .max_out_credits_p(MAX)
  ) dut (
    .clk_i(clk), .reset_i(rst), .my_x_i(my_x), .my_y_i(my_y),
    .stream_v_i(stream_v), .stream_data_i(stream_data), .stream_ready_o(stream_ready),
    .packet_o(packet), .v_o(v), .ready_i(ready),
    .credit_return_v_i(ret), .credits_used_o(credits), .done_o(done), .error_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [SDW-1:0] flitq[$];
  pkt_t           got[$];
  int             got_cyc[$];
  rec_t           exp[$];
  int             model_cnt, cyc, flits_acc;
  bit             model_err, viol, unstable, held_v;
  logic [PW-1:0]  held;
  int             n_checks, n_fail;

  function automatic pkt_t exp_pkt(input rec_t r);
    pkt_t p;
    p.addr    = r.epa[AW-1:0];
    p.op      = 2'b01;
    p.op_ex   = 4'b1111;
    p.payload = r.data;
    p.load_id = '0;
    p.src_y   = my_y;
    p.src_x   = my_x;
    p.y       = r.y[YW-1:0];
    p.x       = r.x[XW-1:0];
    return p;
  endfunction

  // One clock: observe handshakes at the falling edge, then advance the flit feeder.
  task automatic tick();
    bit hs, iss;
    logic [SDW-1:0] dummy;
    hs = 1'b0;
    @(negedge clk);
    if (!rst) begin
      hs  = stream_v && stream_ready;
      iss = v && ready;
      if (hs) flits_acc++;
      if (v && model_cnt >= MAX) viol = 1'b1;
      if (held_v && v && packet !== held) unstable = 1'b1;
      held_v = v && !ready;
      held   = packet;
      if (iss) begin
        got.push_back(pkt_t'(packet));
        got_cyc.push_back(cyc);
      end
      if (iss && !ret) model_cnt++;
      else if (ret && !iss) begin
        if (model_cnt == 0) model_err = 1'b1;
        else model_cnt--;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hs && flitq.size() != 0) dummy = flitq.pop_front();
    stream_v    = (flitq.size() != 0);
    stream_data = stream_v ? flitq[0] : '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pkts(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) tick();
  endtask

  task automatic push_rec(input rec_t r);
    logic [95:0] w;
    w = {16'h0, r};
    flitq.push_back(w[31:0]);
    flitq.push_back(w[63:32]);
    flitq.push_back(w[95:64]);
  endtask

  task automatic push_store();
    rec_t r;
    r.x    = 8'($urandom_range(0, 254));
    r.y    = 8'($urandom);
    r.epa  = $urandom;
    r.data = $urandom;
    exp.push_back(r);
    push_rec(r);
  endtask

  task automatic push_ctrl(input logic [31:0] epa, input logic [31:0] data);
    rec_t r;
    r.x = 8'hff; r.y = 8'hff; r.epa = epa; r.data = data;
    push_rec(r);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    flitq.delete(); got.delete(); got_cyc.delete(); exp.delete();
    stream_v = 1'b0; stream_data = '0; ready = 1'b0; ret = 1'b0;
    model_cnt = 0; model_err = 1'b0; viol = 1'b0; unstable = 1'b0; held_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL reset_v: got %b want 0", v); end
    n_checks++; if (stream_ready !== 1'b0) begin n_fail++; $display("FAIL reset_stream_ready: got %b want 0", stream_ready); end
    n_checks++; if (credits !== '0) begin n_fail++; $display("FAIL reset_credits: got %0d want 0", credits); end
    n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b want 00", {done, err}); end
    n_checks++; if (packet !== '0) begin n_fail++; $display("FAIL reset_packet: got %h want 0", packet); end
    apply_reset();
  endtask

  task automatic test_stores_finish();
    apply_reset();
    repeat (3) push_store();
    push_ctrl(32'h5, $urandom);      // ctrl record that is neither fence nor finish
    push_ctrl(32'hffff_ffff, 32'hffff_ffff);
    for (int i = 0; i < 100 && !(got.size() == 3 && flitq.size() == 0); i++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    ready = 1'b1;
    ticks(5);
    n_checks++; if (got.size() !== 3) begin n_fail++; $display("FAIL t1_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_pkt(exp[i])) begin n_fail++; $display("FAIL t1_pkt%0d: got %h want %h", i, got[i], exp_pkt(exp[i])); end
    end
    n_checks++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL t1_stable: got %b want 0", unstable); end
    n_checks++; if (credits !== CW'(model_cnt)) begin n_fail++; $display("FAIL t1_credits: got %0d want %0d", credits, model_cnt); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL t1_done_early: got %b want 0", done); end
    ret = 1'b1;
    ticks(3);
    ret = 1'b0;
    n_checks++; if (credits !== '0) begin n_fail++; $display("FAIL t1_credits_zero: got %0d want 0", credits); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL t1_done_same_cycle: got %b want 0", done); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL t1_done: got %b want 1", done); end
    push_store();
    ticks(6);
    n_checks++; if ({stream_ready, v, done, err} !== 4'b0010) begin n_fail++; $display("FAIL t1_done_idle: got %b want 0010", {stream_ready, v, done, err}); end
  endtask

  task automatic test_credit_limit();
    apply_reset();
    ready = 1'b1;
    repeat (10) push_store();
    ticks(40);
    n_checks++; if (got.size() !== MAX) begin n_fail++; $display("FAIL t2_count: got %0d want %0d", got.size(), MAX); end
    n_checks++; if ({v, viol} !== 2'b00) begin n_fail++; $display("FAIL t2_v_low: got %b want 00", {v, viol}); end
    n_checks++; if (credits !== CW'(MAX)) begin n_fail++; $display("FAIL t2_credits: got %0d want %0d", credits, MAX); end
    for (int i = 1; i < got_cyc.size() && i < MAX; i++) begin
      n_checks++;
      if (got_cyc[i] - got_cyc[i-1] !== 3) begin n_fail++; $display("FAIL t2_rate%0d: got %0d want 3", i, got_cyc[i] - got_cyc[i-1]); end
    end
    ret = 1'b1; tick(); ret = 1'b0;
    ticks(10);
    n_checks++; if (got.size() !== MAX + 1) begin n_fail++; $display("FAIL t2_one_more: got %0d want %0d", got.size(), MAX + 1); end
    for (int i = 0; i < got.size() && i <= MAX; i++) begin
      n_checks++;
      if (got[i] !== exp_pkt(exp[i])) begin n_fail++; $display("FAIL t2_pkt%0d: got %h want %h", i, got[i], exp_pkt(exp[i])); end
    end
    n_checks++; if (viol !== 1'b0) begin n_fail++; $display("FAIL t2_viol: got %b want 0", viol); end
  endtask

  task automatic test_fence();
    apply_reset();
    ready = 1'b1;
    push_store(); push_store();
    push_ctrl(32'h0, $urandom);
    push_store();
    wait_pkts(2, 30);
    ticks(20);
    n_checks++; if (got.size() !== 2) begin n_fail++; $display("FAIL t3_blocked: got %0d want 2", got.size()); end
    ret = 1'b1; tick(); ret = 1'b0;
    ticks(20);
    n_checks++; if (got.size() !== 2) begin n_fail++; $display("FAIL t3_still_blocked: got %0d want 2", got.size()); end
    ret = 1'b1; tick(); ret = 1'b0;
    wait_pkts(3, 20);
    n_checks++; if (got.size() !== 3) begin n_fail++; $display("FAIL t3_released: got %0d want 3", got.size()); end
    if (got.size() == 3) begin
      n_checks++;
      if (got[2] !== exp_pkt(exp[2])) begin n_fail++; $display("FAIL t3_pkt2: got %h want %h", got[2], exp_pkt(exp[2])); end
    end
    n_checks++; if (credits !== CW'(model_cnt)) begin n_fail++; $display("FAIL t3_credits: got %0d want %0d", credits, model_cnt); end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    ready = 1'b1;
    repeat (MAX - 1) push_store();
    wait_pkts(MAX - 1, 30);
    ready = 1'b0;
    repeat (2) push_store();
    for (int i = 0; i < 20 && !v; i++) tick();
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL t4_pending: got %b want 1", v); end
    ready = 1'b1; ret = 1'b1; tick(); ready = 1'b0; ret = 1'b0;
    n_checks++; if (credits !== CW'(MAX - 1)) begin n_fail++; $display("FAIL t4_both: got %0d want %0d", credits, MAX - 1); end
    n_checks++; if (got.size() !== MAX) begin n_fail++; $display("FAIL t4_issued: got %0d want %0d", got.size(), MAX); end
    ready = 1'b1;
    wait_pkts(MAX + 1, 10);
    n_checks++; if (credits !== CW'(MAX)) begin n_fail++; $display("FAIL t4_full: got %0d want %0d", credits, MAX); end
    push_store();
    ticks(10);
    n_checks++; if ({v, viol} !== 2'b00) begin n_fail++; $display("FAIL t4_blocked: got %b want 00", {v, viol}); end
    n_checks++; if (got.size() !== MAX + 1) begin n_fail++; $display("FAIL t4_blocked_cnt: got %0d want %0d", got.size(), MAX + 1); end
    ret = 1'b1; tick(); ret = 1'b0;
    wait_pkts(MAX + 2, 10);
    n_checks++; if (got.size() !== MAX + 2) begin n_fail++; $display("FAIL t4_net_return: got %0d want %0d", got.size(), MAX + 2); end
    n_checks++; if (credits !== CW'(model_cnt)) begin n_fail++; $display("FAIL t4_credits: got %0d want %0d", credits, model_cnt); end
    for (int i = 0; i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_pkt(exp[i])) begin n_fail++; $display("FAIL t4_pkt%0d: got %h want %h", i, got[i], exp_pkt(exp[i])); end
    end
  endtask

  task automatic test_error();
    apply_reset();
    ticks(2);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL t5_err_clear: got %b want 0", err); end
    ret = 1'b1; tick(); ret = 1'b0;
    tick();
    n_checks++; if (err !== model_err) begin n_fail++; $display("FAIL t5_err_set: got %b want %b", err, model_err); end
    n_checks++; if (credits !== '0) begin n_fail++; $display("FAIL t5_count_zero: got %0d want 0", credits); end
    ready = 1'b1;
    push_store();
    wait_pkts(1, 10);
    ret = 1'b1; tick(); ret = 1'b0;
    ticks(5);
    n_checks++; if ({err, credits} !== {1'b1, CW'(0)}) begin n_fail++; $display("FAIL t5_sticky: got %b/%0d want 1/0", err, credits); end
  endtask

  task automatic test_reset_mid_record();
    int start;
    rec_t r;
    apply_reset();
    ready = 1'b1;
    push_store();
    wait_pkts(1, 10);
    n_checks++; if (credits !== 1) begin n_fail++; $display("FAIL t6_pre_credits: got %0d want 1", credits); end
    push_store();
    start = flits_acc;
    for (int i = 0; i < 10 && flits_acc < start + 1; i++) tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({v, stream_ready, done, err} !== 4'b0000 || credits !== '0 || packet !== '0) begin
      n_fail++;
      $display("FAIL t6_async: got v%b rdy%b d%b e%b c%0d p%h want all 0", v, stream_ready, done, err, credits, packet);
    end
    apply_reset();
    ready = 1'b1;
    r.x = 8'h2c; r.y = 8'h13; r.epa = $urandom; r.data = $urandom;
    exp.push_back(r);
    push_rec(r);
    wait_pkts(1, 15);
    n_checks++; if (got.size() !== 1) begin n_fail++; $display("FAIL t6_fresh_cnt: got %0d want 1", got.size()); end
    if (got.size() >= 1) begin
      n_checks++;
      if (got[0] !== exp_pkt(r)) begin n_fail++; $display("FAIL t6_fresh_pkt: got %h want %h", got[0], exp_pkt(r)); end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; flits_acc = 0;
    my_x = 7'h15; my_y = 7'h2a;
    rst = 1'b1; stream_v = 1'b0; stream_data = '0; ready = 1'b0; ret = 1'b0;
    held = '0;
    test_reset();
    test_stores_finish();
    test_credit_limit();
    test_fence();
    test_same_cycle();
    test_error();
    test_reset_mid_record();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
